gate_arbiter: RTL and testbench
===============================

GATE_ARBITER -- requirements
Module: gate_arbiter

Interface
REQ-001 Parameter N_REQ, default 4: number of requesters sharing the logic unit (2..8).
REQ-002 Parameter WIDTH, default 8: operand and result width in bits.
REQ-003 Port clk, input, 1: the single clock; all state updates on the rising edge.
REQ-004 Port rst, input, 1: reset, synchronous and active-high.
REQ-005 Port req_valid, input, N_REQ: bit i set means requester i presents an operation.
REQ-006 Port req_op, input, 3*N_REQ: opcode per requester, packed; slice i is [3i+2:3i].
REQ-007 Port req_a, input, WIDTH*N_REQ: operand A per requester, packed.
REQ-008 Port req_b, input, WIDTH*N_REQ: operand B per requester, packed.
REQ-009 Port req_ready, output, N_REQ: one-hot grant; request i is accepted when req_valid[i] and req_ready[i] are both high at a clock edge.
REQ-010 Port res_valid, output, 1: result available.
REQ-011 Port res_ready, input, 1: consumer accepts the result.
REQ-012 Port res_data, output, WIDTH: computed result.
REQ-013 Port res_id, output, 3: index of the requester that owns res_data.
REQ-014 Port res_err, output, 1: opcode was illegal.

Function
REQ-015 Opcodes (bitwise over WIDTH bits) SHALL be: 000 AND, 001 OR, 010 XOR, 011 NAND, 100 NOR, 101 XNOR; 110 and 111 are illegal.
REQ-016 An illegal opcode SHALL yield res_data=0 and res_err=1; a legal opcode SHALL yield res_err=0.
REQ-017 FSM states SHALL be IDLE, EXEC and RESP.
REQ-018 In IDLE with any req_valid bit high, req_ready SHALL combinationally select one winner: the first valid index at or after ptr, searched in ascending order with wrap-around.
REQ-019 req_ready SHALL be all-zero in EXEC, in RESP, during rst, and in IDLE when no req_valid bit is high.
REQ-020 On acceptance, the winner's op, a, b and index SHALL be captured, and the FSM SHALL go IDLE->EXEC.
REQ-021 In EXEC, the result SHALL be registered into res_data, res_err and res_id; the FSM SHALL go EXEC->RESP.
REQ-022 In RESP, res_valid SHALL be 1; the FSM SHALL go RESP->IDLE on res_valid and res_ready both high.
REQ-023 On that same edge, res_valid SHALL clear and ptr SHALL become (res_id+1) mod N_REQ.
REQ-024 Latency: an acceptance at edge T SHALL produce res_valid high from edge T+2.
REQ-025 Peak throughput with res_ready tied high SHALL be one operation per 3 cycles.
REQ-026 While res_ready is low in RESP, res_data, res_id and res_err SHALL hold stable.
REQ-027 req_valid changes outside IDLE SHALL have no effect; non-granted requesters simply wait.
REQ-028 A lone continuously valid requester SHALL be granted on every pass through IDLE.
REQ-029 With all requesters valid, grants SHALL rotate 0,1,2,...,N_REQ-1,0 with no starvation.

Reset
REQ-030 When rst is high at an edge, the block SHALL set state=IDLE, ptr=0, res_valid=0, res_data=0, res_id=0, res_err=0 and clear the captured operands.
REQ-031 A reset asserted in EXEC or RESP SHALL discard the pending result with no res_valid pulse; the owning requester is not re-granted automatically.
REQ-032 The first grant after reset release SHALL search from index 0.

Structure
REQ-033 Package gate_pkg SHALL hold the opcode localparams, the FSM state typedef and the opcode width constant (3).
REQ-034 Sub-module gate_logic_unit SHALL be purely combinational and implement REQ-015/016 over WIDTH bits; it SHALL be instantiated once and fed from the captured registers.
REQ-035 The arbiter, FSM and output registers SHALL reside in gate_arbiter.

Verification
REQ-036 Reset then idle: all outputs zero, req_ready=0000 for 5 cycles.
REQ-037 Single op: req0 AND, a=8'hF0, b=8'h3C, res_ready=1 -> accepted at T, res_valid at T+2 with res_data=8'h30, res_id=0, res_err=0.
REQ-038 All ops: a=8'hA5, b=8'h0F through opcodes 000..111 -> results 05, AF, AA, FA, 50, 55, then 00 with res_err=1 for both 110 and 111.
REQ-039 Fairness: all 4 requesters permanently valid -> grant order 0,1,2,3,0,1 (by res_id).
REQ-040 Backpressure: res_ready=0 for 6 cycles in RESP -> outputs stable, req_ready=0; result consumed on the edge res_ready rises, IDLE on the next cycle.
REQ-041 Reset mid-op: rst pulsed in EXEC -> no res_valid, ptr=0, next grant to lowest valid index.

Source files
------------

// File: rtl/gate_pkg.sv
// Shared opcode encodings, FSM state type and index widths for the gate arbiter.
package gate_pkg;

    localparam int OP_W = 3;
    localparam int ID_W = 3;

    localparam logic [OP_W-1:0] OP_AND  = 3'b000;
    localparam logic [OP_W-1:0] OP_OR   = 3'b001;
    localparam logic [OP_W-1:0] OP_XOR  = 3'b010;
    localparam logic [OP_W-1:0] OP_NAND = 3'b011;
    localparam logic [OP_W-1:0] OP_NOR  = 3'b100;
    localparam logic [OP_W-1:0] OP_XNOR = 3'b101;

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_EXEC,
        ST_RESP
    } state_e;

endpackage

// File: rtl/gate_logic_unit.sv
// Combinational bitwise logic unit; opcodes 110/111 are illegal and return zero with err set.
module gate_logic_unit
    import gate_pkg::*;
#(
    parameter int WIDTH = 8
) (
    input  logic [OP_W-1:0]  op_i,
    input  logic [WIDTH-1:0] a_i,
    input  logic [WIDTH-1:0] b_i,
    output logic [WIDTH-1:0] y_o,
    output logic             err_o
);

    always_comb begin
        // NOTE: defaults first so every path assigns both outputs and no latch is inferred.
        y_o   = '0;
        err_o = 1'b0;
        case (op_i)
            OP_AND:  y_o = a_i & b_i;
            OP_OR:   y_o = a_i | b_i;
            OP_XOR:  y_o = a_i ^ b_i;
            OP_NAND: y_o = ~(a_i & b_i);
            OP_NOR:  y_o = ~(a_i | b_i);
            OP_XNOR: y_o = ~(a_i ^ b_i);
            default: err_o = 1'b1;
        endcase
    end

endmodule

// File: rtl/gate_arbiter.sv
// Round-robin arbiter feeding one shared logic unit; one operation in flight at a time
// through IDLE (grant) -> EXEC (compute) -> RESP (hold result until consumed).
module gate_arbiter
    import gate_pkg::*;
#(
    parameter int N_REQ = 4,
    parameter int WIDTH = 8
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic [N_REQ-1:0]        req_valid,
    input  logic [OP_W*N_REQ-1:0]   req_op,
    input  logic [WIDTH*N_REQ-1:0]  req_a,
    input  logic [WIDTH*N_REQ-1:0]  req_b,
    output logic [N_REQ-1:0]        req_ready,
    output logic                    res_valid,
    input  logic                    res_ready,
    output logic [WIDTH-1:0]        res_data,
    output logic [ID_W-1:0]         res_id,
    output logic                    res_err
);

    state_e            state_q, state_d;
    logic [ID_W-1:0]   ptr_q, ptr_d;
    logic [ID_W-1:0]   id_q, id_d;
    logic [OP_W-1:0]   op_q, op_d;
    logic [WIDTH-1:0]  a_q, a_d;
    logic [WIDTH-1:0]  b_q, b_d;
    logic [WIDTH-1:0]  res_data_q, res_data_d;
    logic [ID_W-1:0]   res_id_q, res_id_d;
    logic              res_err_q, res_err_d;

    logic              grant_found;
    logic [ID_W-1:0]   grant_idx;
    logic [ID_W-1:0]   cand;
    logic [WIDTH-1:0]  lu_y;
    logic              lu_err;

    function automatic logic [ID_W-1:0] wrap_add(input logic [ID_W-1:0] base, input int off);
        int sum;
        sum = int'(base) + off;
        if (sum >= N_REQ) sum = sum - N_REQ;
        return ID_W'(sum);
    endfunction

    // Walk offsets high to low so the smallest offset from ptr_q is the last writer and wins.
    always_comb begin
        grant_found = 1'b0;
        grant_idx   = '0;
        cand        = '0;
        for (int k = N_REQ - 1; k >= 0; k--) begin
            cand = wrap_add(ptr_q, k);
            if (|(req_valid & (N_REQ'(1) << cand))) begin
                grant_found = 1'b1;
                grant_idx   = cand;
            end
        end
    end

    gate_logic_unit #(
        .WIDTH (WIDTH)
    ) u_logic (
        .op_i  (op_q),
        .a_i   (a_q),
        .b_i   (b_q),
        .y_o   (lu_y),
        .err_o (lu_err)
    );

    always_comb begin
        state_d    = state_q;
        ptr_d      = ptr_q;
        id_d       = id_q;
        op_d       = op_q;
        a_d        = a_q;
        b_d        = b_q;
        res_data_d = res_data_q;
        res_id_d   = res_id_q;
        res_err_d  = res_err_q;
        req_ready  = '0;
        case (state_q)
            ST_IDLE: begin
                if (grant_found && !rst) begin
                    req_ready = N_REQ'(1) << grant_idx;
                    id_d      = grant_idx;
                    op_d      = OP_W'(req_op >> (OP_W * int'(grant_idx)));
                    a_d       = WIDTH'(req_a >> (WIDTH * int'(grant_idx)));
                    b_d       = WIDTH'(req_b >> (WIDTH * int'(grant_idx)));
                    state_d   = ST_EXEC;
                end
            end
            ST_EXEC: begin
                res_data_d = lu_y;
                res_err_d  = lu_err;
                res_id_d   = id_q;
                state_d    = ST_RESP;
            end
            ST_RESP: begin
                if (res_ready) begin
                    ptr_d   = wrap_add(res_id_q, 1);
                    state_d = ST_IDLE;
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        // NOTE: non-blocking assignments so every register samples pre-edge values.
        if (rst) begin
            state_q    <= ST_IDLE;
            ptr_q      <= '0;
            id_q       <= '0;
            op_q       <= '0;
            a_q        <= '0;
            b_q        <= '0;
            res_data_q <= '0;
            res_id_q   <= '0;
            res_err_q  <= 1'b0;
        end else begin
            state_q    <= state_d;
            ptr_q      <= ptr_d;
            id_q       <= id_d;
            op_q       <= op_d;
            a_q        <= a_d;
            b_q        <= b_d;
            res_data_q <= res_data_d;
            res_id_q   <= res_id_d;
            res_err_q  <= res_err_d;
        end
    end

    // Masked by rst so a pending result never escapes while it is being discarded.
    assign res_valid = (state_q == ST_RESP) && !rst;
    assign res_data  = res_data_q;
    assign res_id    = res_id_q;
    assign res_err   = res_err_q;

endmodule

// File: tb/tb_gate_arbiter.sv
// Scoreboard bench for gate_arbiter: a cycle model predicts grants and results at each falling edge.
module tb_gate_arbiter;

    localparam int N = 4;
    localparam int W = 8;

    logic             clk = 1'b0;
    logic             rst;
    logic [N-1:0]     req_valid;
    logic [3*N-1:0]   req_op;
    logic [W*N-1:0]   req_a;
    logic [W*N-1:0]   req_b;
    logic [N-1:0]     req_ready;
    logic             res_valid;
    logic             res_ready;
    logic [W-1:0]     res_data;
    logic [2:0]       res_id;
    logic             res_err;

    always #5 clk = ~clk;

    gate_arbiter #(
        .N_REQ (N),
        .WIDTH (W)
    ) dut (
        .clk       (clk),
        .rst       (rst),
        .req_valid (req_valid),
        .req_op    (req_op),
        .req_a     (req_a),
        .req_b     (req_b),
        .req_ready (req_ready),
        .res_valid (res_valid),
        .res_ready (res_ready),
        .res_data  (res_data),
        .res_id    (res_id),
        .res_err   (res_err)
    );

    typedef struct {
        logic [7:0] data;
        logic [2:0] id;
        logic       err;
    } exp_t;

    typedef enum {M_IDLE, M_EXEC, M_RESP} mstate_e;

    exp_t       sb[$];
    int         id_log[$];
    int         data_log[$];
    int         n_checks = 0;
    int         n_fail = 0;
    int         n_consumed = 0;
    mstate_e    m_state = M_IDLE;
    int         m_ptr = 0;
    logic       held = 1'b0;
    logic [7:0] hold_data;
    logic [2:0] hold_id;
    logic       hold_err;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got=%0h expected=%0h at %0t", tag, got, exp, $time);
        end
    endtask

    // Returns {err, data}.
    function automatic logic [8:0] model_op(input logic [2:0] op, input logic [7:0] a, input logic [7:0] b);
        case (op)
            3'd0:    return {1'b0, a & b};
            3'd1:    return {1'b0, a | b};
            3'd2:    return {1'b0, a ^ b};
            3'd3:    return {1'b0, ~(a & b)};
            3'd4:    return {1'b0, ~(a | b)};
            3'd5:    return {1'b0, ~(a ^ b)};
            default: return {1'b1, 8'h00};
        endcase
    endfunction

    function automatic int model_grant(input logic [N-1:0] v, input int p);
        for (int k = 0; k < N; k++) begin
            if (((v >> ((p + k) % N)) & 1) != 0) return (p + k) % N;
        end
        return -1;
    endfunction

    // Predicts what the next rising edge will do, checking the outputs visible now.
    always @(negedge clk) begin : monitor
        int         w;
        logic [8:0] r;
        exp_t       e;
        if (rst) begin
            check("rst_ready", req_ready, 0);
            check("rst_valid", res_valid, 0);
            m_state = M_IDLE;
            m_ptr   = 0;
            held    = 1'b0;
            sb.delete();
        end else begin
            case (m_state)
                M_IDLE: begin
                    check("idle_valid", res_valid, 0);
                    w = model_grant(req_valid, m_ptr);
                    if (w < 0) begin
                        check("idle_ready", req_ready, 0);
                    end else begin
                        check("grant", req_ready, 32'(1 << w));
                        r = model_op(req_op[3*w +: 3], req_a[8*w +: 8], req_b[8*w +: 8]);
                        sb.push_back('{data: r[7:0], id: 3'(w), err: r[8]});
                        m_state = M_EXEC;
                    end
                end
                M_EXEC: begin
                    check("exec_ready", req_ready, 0);
                    check("exec_valid", res_valid, 0);
                    held    = 1'b0;
                    m_state = M_RESP;
                end
                default: begin
                    check("resp_valid", res_valid, 1);
                    check("resp_ready", req_ready, 0);
                    if (held) begin
                        check("hold_data", res_data, hold_data);
                        check("hold_id", res_id, hold_id);
                        check("hold_err", res_err, hold_err);
                    end
                    hold_data = res_data;
                    hold_id   = res_id;
                    hold_err  = res_err;
                    held      = 1'b1;
                    if (res_ready) begin
                        check("sb_size", sb.size(), 1);
                        if (sb.size() > 0) begin
                            e = sb.pop_front();
                            check("res_data", res_data, e.data);
                            check("res_id", res_id, e.id);
                            check("res_err", res_err, e.err);
                            m_ptr = (int'(e.id) + 1) % N;
                        end
                        id_log.push_back(int'(res_id));
                        data_log.push_back(int'(res_data));
                        n_consumed++;
                        held    = 1'b0;
                        m_state = M_IDLE;
                    end
                end
            endcase
        end
    end

    // Called just after a rising edge; returns just after the accepting edge.
    task automatic send_one(input int i, input logic [2:0] op, input logic [7:0] a, input logic [7:0] b);
        logic acc;
        acc = 1'b0;
        req_valid = '0;
        req_valid[i] = 1'b1;
        req_op[3*i +: 3] = op;
        req_a[8*i +: 8]  = a;
        req_b[8*i +: 8]  = b;
        for (int c = 0; c < 20 && !acc; c++) begin
            @(negedge clk);
            acc = ((req_ready >> i) & 1) != 0;
            @(posedge clk);
            #1;
        end
        req_valid = '0;
        check("send_accepted", acc, 1);
    endtask

    task automatic wait_drain(input int budget);
        int c;
        c = 0;
        while ((sb.size() != 0 || m_state != M_IDLE) && c < budget) begin
            @(posedge clk);
            #1;
            c++;
        end
        check("drain", (sb.size() == 0 && m_state == M_IDLE), 1);
    endtask

    initial begin : watchdog
        #200000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1);
    end

    initial begin : stim
        logic [7:0] all_ops_exp[8];
        int         fair_exp[6];
        int         base;
        int         c;
        int         saved;

        all_ops_exp = '{8'h05, 8'hAF, 8'hAA, 8'hFA, 8'h50, 8'h55, 8'h00, 8'h00};
        fair_exp    = '{0, 1, 2, 3, 0, 1};

        rst = 1'b1; req_valid = '0; req_op = '0; req_a = '0; req_b = '0; res_ready = 1'b1;
        repeat (2) @(posedge clk);
        #1 rst = 1'b0;

        // Idle after reset: everything quiet.
        repeat (5) begin
            @(negedge clk);
            check("idle_res_valid", res_valid, 0);
            check("idle_res_data", res_data, 0);
            check("idle_res_id", res_id, 0);
            check("idle_res_err", res_err, 0);
            check("idle_req_ready", req_ready, 0);
        end
        @(posedge clk);
        #1;

        // Single AND on requester 0.
        base = data_log.size();
        send_one(0, 3'b000, 8'hF0, 8'h3C);
        wait_drain(20);
        check("single_data", data_log[base], 8'h30);
        check("single_id", id_log[base], 0);

        // Every opcode, spread over the requesters.
        base = data_log.size();
        for (int op = 0; op < 8; op++) begin
            send_one(op % N, 3'(op), 8'hA5, 8'h0F);
            wait_drain(20);
        end
        for (int op = 0; op < 8; op++) check($sformatf("allops_%0d", op), data_log[base + op], all_ops_exp[op]);

        // Fairness with everyone asking, starting from a fresh reset.
        rst = 1'b1;
        @(posedge clk);
        #1 rst = 1'b0;
        base = id_log.size();
        for (int i = 0; i < N; i++) begin
            req_op[3*i +: 3] = 3'(i);
            req_a[8*i +: 8]  = 8'(8'h11 * (i + 1));
            req_b[8*i +: 8]  = 8'hC3 ^ 8'(i);
        end
        req_valid = '1;
        c = 0;
        while (n_consumed < base + 6 && c < 100) begin
            @(posedge clk);
            #1;
            c++;
        end
        req_valid = '0;
        check("fair_done", n_consumed >= base + 6, 1);
        wait_drain(20);
        for (int k = 0; k < 6; k++) check($sformatf("fair_%0d", k), id_log[base + k], fair_exp[k]);

        // Backpressure: hold the result while another requester waits.
        base = id_log.size();
        res_ready = 1'b0;
        send_one(2, 3'b010, 8'h3C, 8'hFF);
        req_valid = 4'b1000;
        req_op[9 +: 3] = 3'b001;
        req_a[24 +: 8] = 8'h81;
        req_b[24 +: 8] = 8'h18;
        repeat (7) begin
            @(posedge clk);
            #1;
        end
        res_ready = 1'b1;
        repeat (2) begin
            @(posedge clk);
            #1;
        end
        req_valid = '0;
        wait_drain(20);
        check("bp_first_id", id_log[base], 2);
        check("bp_first_data", data_log[base], 8'hC3);
        check("bp_second_id", id_log[base + 1], 3);

        // Reset while a result is being computed.
        send_one(1, 3'b000, 8'h0F, 8'hFF);
        wait_drain(20);
        saved = n_consumed;
        send_one(2, 3'b000, 8'hFF, 8'hFF);
        rst = 1'b1;
        @(posedge clk);
        #1 rst = 1'b0;
        repeat (4) begin
            @(negedge clk);
            check("rst_no_valid", res_valid, 0);
        end
        check("rst_discard", n_consumed, saved);
        @(posedge clk);
        #1;
        base = id_log.size();
        req_valid = 4'b1010;
        @(negedge clk);
        check("post_rst_grant", req_ready, 4'b0010);
        @(posedge clk);
        #1 req_valid = '0;
        wait_drain(20);
        check("post_rst_id", id_log[base], 1);

        check("sb_left", sb.size(), 0);
        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end

endmodule
